// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Byte lanes are little-endian: lane n holds bits [8n+7:8n] of a word.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_t;

    // Byte wins over Half when both strobes are set.
    function automatic acc_size_t decode_size(input logic is_byte, input logic is_half);
        acc_size_t sz;
        if (is_byte) begin
            sz = SZ_BYTE;
        end else if (is_half) begin
            sz = SZ_HALF;
        end else begin
            sz = SZ_WORD;
        end
        return sz;
    endfunction

    function automatic logic [3:0] byte_enable(input acc_size_t sz, input logic [1:0] lane);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input acc_size_t sz,
                                                 input logic [1:0] lane, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: res = {{24{sext & b[7]}}, b};
            SZ_HALF: res = {{16{sext & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module byte_lane_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: captures a held load/store, waits LATENCY
// cycles (the last of which is the Ack cycle), then reports data and errors.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Byte,
    input  logic        Half,
    input  logic        SignExtend,
    output logic [31:0] ReadData,
    output logic        Ack,
    output logic        Err,
    output logic        Busy
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    acc_size_t   size_q, size_d;
    logic        sext_q, sext_d;

    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic        eff_rd;
    logic        eff_wr;
    acc_size_t   eff_size;
    logic        req_err;
    logic        fire;
    logic [31:0] wdata_rep;
    logic [31:0] ram_rdata;

    // With LATENCY=1 the access fires in the accepting cycle, before the
    // captured copy exists, so the live inputs feed the access path in IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            eff_addr  = Address;
            eff_wdata = WriteData;
            eff_rd    = MemRead;
            eff_wr    = MemWrite;
            eff_size  = decode_size(Byte, Half);
        end else begin
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_rd    = rd_q;
            eff_wr    = wr_q;
            eff_size  = size_q;
        end
    end

    always_comb begin
        req_err = 1'b0;
        if (eff_rd && eff_wr) begin
            req_err = 1'b1;
        end
        if (eff_size == SZ_HALF && eff_addr[0]) begin
            req_err = 1'b1;
        end
        if (eff_size == SZ_WORD && eff_addr[1:0] != 2'b00) begin
            req_err = 1'b1;
        end
        if (eff_addr[31:2] >= 30'(DEPTH_WORDS)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        case (eff_size)
            SZ_BYTE: wdata_rep = {4{eff_wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{eff_wdata[15:0]}};
            default: wdata_rep = eff_wdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fire    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        size_d  = size_q;
        sext_d  = sext_q;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = Address;
                    wdata_d = WriteData;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    size_d  = decode_size(Byte, Half);
                    sext_d  = SignExtend;
                    if (LATENCY == 1) begin
                        fire    = 1'b1;
                        err_d   = req_err;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    fire    = 1'b1;
                    err_d   = req_err;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Captured request fields are only consulted outside IDLE, so they need no reset.
    always_ff @(posedge CLK) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rd_q    <= rd_d;
        wr_q    <= wr_d;
        size_q  <= size_d;
        sext_q  <= sext_d;
    end

    byte_lane_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (CLK),
        .we   (fire & eff_wr & ~req_err),
        .be   (byte_enable(eff_size, eff_addr[1:0])),
        .addr (eff_addr[AW+1:2]),
        .wdata(wdata_rep),
        .re   (fire & eff_rd & ~req_err),
        .rdata(ram_rdata)
    );

    assign Ack  = (state_q == RESP);
    assign Busy = (state_q != IDLE);
    assign Err  = Ack & err_q;

    always_comb begin
        ReadData = '0;
        if (Ack && rd_q && !err_q) begin
            ReadData = extract_load(ram_rdata, size_q, addr_q[1:0], sext_q);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three latencies driven from shared inputs, each
// checked every cycle against a busy-countdown model with a flat memory image.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        Byte = 1'b0;
    logic        Half = 1'b0;
    logic        SignExtend = 1'b0;

    logic [31:0] rd_o   [3];
    logic        ack_o  [3];
    logic        err_o  [3];
    logic        busy_o [3];

    int lat [3] = '{2, 1, 4};
    int checks = 0;
    int fails  = 0;

    always #5 CLK = ~CLK;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
        .CLK(CLK), .RST(RST), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .Byte(Byte), .Half(Half),
        .SignExtend(SignExtend), .ReadData(rd_o[0]), .Ack(ack_o[0]),
        .Err(err_o[0]), .Busy(busy_o[0]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
        .CLK(CLK), .RST(RST), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .Byte(Byte), .Half(Half),
        .SignExtend(SignExtend), .ReadData(rd_o[1]), .Ack(ack_o[1]),
        .Err(err_o[1]), .Busy(busy_o[1]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_lat4 (
        .CLK(CLK), .RST(RST), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .Byte(Byte), .Half(Half),
        .SignExtend(SignExtend), .ReadData(rd_o[2]), .Ack(ack_o[2]),
        .Err(err_o[2]), .Busy(busy_o[2]));

    // Model state: bc = busy cycles remaining (1 means this is the Ack cycle).
    int          bc     [3];
    logic [31:0] ca     [3];
    logic [31:0] cwd    [3];
    bit          crd    [3];
    bit          cwr    [3];
    bit          cby    [3];
    bit          chf    [3];
    bit          cse    [3];
    bit          x_err  [3];
    logic [31:0] x_data [3];
    bit          x_known[3];
    logic [31:0] mmem   [3][DEPTH];
    bit          mknown [3][DEPTH];

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[u%0d] at %0t: got %h, expected %h", nm, inst, $time, act, exp);
        end
    endtask

    task automatic execute(input int i);
        int          w;
        int          sh;
        logic [31:0] v;
        logic [31:0] mask;
        logic [1:0]  lane;
        w    = int'(ca[i][31:2]);
        lane = ca[i][1:0];
        x_err[i] = (crd[i] && cwr[i]) ||
                   (!cby[i] && chf[i] && lane[0]) ||
                   (!cby[i] && !chf[i] && lane != 2'd0) ||
                   (w >= DEPTH);
        x_data[i]  = '0;
        x_known[i] = 1'b0;
        if (!x_err[i] && cwr[i]) begin
            if (cby[i]) begin
                sh = 8 * lane;      mask = 32'hFF << sh;
            end else if (chf[i]) begin
                sh = 16 * lane[1];  mask = 32'hFFFF << sh;
            end else begin
                sh = 0;             mask = 32'hFFFF_FFFF;
            end
            mmem[i][w] = (mmem[i][w] & ~mask) | ((cwd[i] << sh) & mask);
            if (!cby[i] && !chf[i]) mknown[i][w] = 1'b1;
        end
        if (!x_err[i] && crd[i]) begin
            v = mmem[i][w];
            x_known[i] = mknown[i][w];
            if (cby[i]) begin
                v = (v >> (8 * lane)) & 32'hFF;
                if (cse[i] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (chf[i]) begin
                v = (v >> (16 * lane[1])) & 32'hFFFF;
                if (cse[i] && v[15]) v = v | 32'hFFFF_0000;
            end
            x_data[i] = v;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            bc[i] = 0;
            for (int k = 0; k < DEPTH; k++) mmem[i][k] = '0;
        end
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                for (int i = 0; i < 3; i++) bc[i] = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (bc[i] > 0) begin
                        bc[i]--;
                    end else if (MemRead || MemWrite) begin
                        ca[i] = Address;   cwd[i] = WriteData;
                        crd[i] = MemRead;  cwr[i] = MemWrite;
                        cby[i] = Byte;     chf[i] = Half;  cse[i] = SignExtend;
                        bc[i] = lat[i];
                    end
                    if (bc[i] == 1) execute(i);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #2;
            for (int i = 0; i < 3; i++) begin
                bit xa;
                xa = (bc[i] == 1);
                chk("ack", i, {31'd0, ack_o[i]}, {31'd0, xa});
                chk("busy", i, {31'd0, busy_o[i]}, {31'd0, bc[i] > 0});
                chk("err", i, {31'd0, err_o[i]}, {31'd0, xa && x_err[i]});
                if (!xa || x_err[i]) begin
                    chk("rdata_idle", i, rd_o[i], 32'h0);
                end else if (crd[i] && x_known[i]) begin
                    chk("rdata", i, rd_o[i], x_data[i]);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input bit r, input bit w,
                          input bit by, input bit hf, input bit se, input int gap,
                          output logic [31:0] rdv, output bit er, output int lt);
        bit got;
        @(negedge CLK);
        Address = a; WriteData = wd; MemRead = r; MemWrite = w;
        Byte = by; Half = hf; SignExtend = se;
        lt = 0; got = 0; rdv = '0; er = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLK);
            lt++;
            if (ack_o[0]) got = 1;
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL ack_timeout: no Ack after %0d cycles, required after %0d", lt, lat[0]);
        end
        rdv = rd_o[0];
        er  = err_o[0];
        MemRead = 0;
        MemWrite = 0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic expect_req(input string nm, input logic [31:0] a, input logic [31:0] wd,
                              input bit r, input bit w, input bit by, input bit hf, input bit se,
                              input logic [31:0] exp_rd, input bit exp_err, input bit check_rd);
        logic [31:0] rdv;
        bit          er;
        int          lt;
        do_req(a, wd, r, w, by, hf, se, 6, rdv, er, lt);
        chk({nm, "_latency"}, 0, lt, 32'd2);
        chk({nm, "_err"}, 0, {31'd0, er}, {31'd0, exp_err});
        if (check_rd) chk({nm, "_data"}, 0, rdv, exp_rd);
    endtask

    initial begin
        logic [31:0] rdv;
        logic [31:0] a;
        bit          er;
        int          lt;
        int          sz;
        bit          r;
        bit          w;
        bit          hf;
        int          last1;
        int          last4;
        int          n1;
        int          n4;

        repeat (3) @(negedge CLK);
        chk("reset_ack", 0, {31'd0, ack_o[0]}, 32'd0);
        chk("reset_busy", 0, {31'd0, busy_o[0]}, 32'd0);
        chk("reset_err", 0, {31'd0, err_o[0]}, 32'd0);
        chk("reset_rdata", 0, rd_o[0], 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        expect_req("st_word10", 32'h10, 32'hDEADBEEF, 0, 1, 0, 0, 0, 32'h0, 0, 0);
        expect_req("ld_word10", 32'h10, 32'h0, 1, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1);
        expect_req("st_byte13", 32'h13, 32'h80, 0, 1, 1, 0, 0, 32'h0, 0, 0);
        expect_req("ld_byte13_sx", 32'h13, 32'h0, 1, 0, 1, 0, 1, 32'hFFFFFF80, 0, 1);
        expect_req("ld_byte13_zx", 32'h13, 32'h0, 1, 0, 1, 0, 0, 32'h00000080, 0, 1);
        expect_req("ld_word10_b", 32'h10, 32'h0, 1, 0, 0, 0, 0, 32'h80ADBEEF, 0, 1);
        expect_req("st_half12", 32'h12, 32'h1234, 0, 1, 0, 1, 0, 32'h0, 0, 0);
        expect_req("ld_word10_h", 32'h10, 32'h0, 1, 0, 0, 0, 0, 32'h1234BEEF, 0, 1);
        expect_req("ld_half11_misal", 32'h11, 32'h0, 1, 0, 0, 1, 1, 32'h0, 1, 1);
        expect_req("st_word04", 32'h4, 32'h55AA55AA, 0, 1, 0, 0, 0, 32'h0, 0, 0);
        expect_req("st_word06_misal", 32'h6, 32'h12345678, 0, 1, 0, 0, 0, 32'h0, 1, 0);
        expect_req("ld_word04", 32'h4, 32'h0, 1, 0, 0, 0, 0, 32'h55AA55AA, 0, 1);
        expect_req("ld_out_of_range", 32'h1000, 32'h0, 1, 0, 0, 0, 0, 32'h0, 1, 1);
        expect_req("rd_and_wr", 32'h10, 32'h0, 1, 1, 0, 0, 0, 32'h0, 1, 1);
        expect_req("ld_word10_kept", 32'h10, 32'h0, 1, 0, 0, 0, 0, 32'h1234BEEF, 0, 1);

        // Reset while the store sits in its wait cycle.
        expect_req("st_word20", 32'h20, 32'h11111111, 0, 1, 0, 0, 0, 32'h0, 0, 0);
        @(negedge CLK);
        Address = 32'h20; WriteData = 32'hCAFEF00D; MemWrite = 1; MemRead = 0; Byte = 0; Half = 0;
        @(negedge CLK);
        chk("busy_before_rst", 0, {31'd0, busy_o[0]}, 32'd1);
        RST = 1'b0;
        MemWrite = 0;
        #1;
        chk("busy_at_rst", 0, {31'd0, busy_o[0]}, 32'd0);
        chk("ack_at_rst", 0, {31'd0, ack_o[0]}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("no_ack_after_rst", 0, {31'd0, ack_o[0]}, 32'd0);
        end
        expect_req("ld_word20", 32'h20, 32'h0, 1, 0, 0, 0, 0, 32'h11111111, 0, 1);

        // Strobes held continuously: acks must be LATENCY+1 apart.
        @(negedge CLK);
        Address = 32'h10; MemRead = 1; MemWrite = 0; Byte = 0; Half = 0; SignExtend = 0;
        last1 = -1; last4 = -1; n1 = 0; n4 = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (ack_o[1]) begin
                if (last1 >= 0) chk("b2b_spacing_l1", 1, c - last1, 32'd2);
                last1 = c;
                n1++;
            end
            if (ack_o[2]) begin
                if (last4 >= 0) chk("b2b_spacing_l4", 2, c - last4, 32'd5);
                last4 = c;
                n4++;
            end
        end
        MemRead = 0;
        chk("b2b_count_l1", 1, n1, 32'd15);
        chk("b2b_count_l4", 2, n4, 32'd6);
        repeat (8) @(negedge CLK);

        for (int n = 0; n < 150; n++) begin
            a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) a = $urandom | 32'h1000;
            sz = $urandom_range(0, 2);
            r  = ($urandom_range(0, 1) == 1);
            w  = r ? ($urandom_range(0, 7) == 0) : 1'b1;
            hf = (sz == 1) || (sz == 0 && $urandom_range(0, 1) == 1);
            do_req(a, $urandom, r, w, sz == 0, hf, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 5), rdv, er, lt);
        end

        repeat (10) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
